// File: rtl/sample_fifo.sv
// Parametrised synchronous FIFO for the temperature-sample path (sensor in, UART out).
// Define FIFO_ERR_FLAGS_EN to enable the sticky overflow/underflow flags.
module sample_fifo #(
  parameter int unsigned DW        = 8,
  parameter int unsigned AW        = 4,
  parameter int unsigned AFULL_TH  = 12,
  parameter int unsigned AEMPTY_TH = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush_i,
  input  logic          wr_en_i,
  input  logic [DW-1:0] wr_data_i,
  input  logic          rd_en_i,
  output logic [DW-1:0] rd_data_o,
  output logic          full_o,
  output logic          empty_o,
  output logic          almost_full_o,
  output logic          almost_empty_o,
  output logic [AW:0]   level_o,
  input  logic          err_clr_i,
  output logic          overflow_o,
  output logic          underflow_o
);

  localparam int unsigned Depth = 2 ** AW;
  localparam int unsigned PtrW  = AW + 1;
  localparam logic [AW:0] AfullTh  = PtrW'(AFULL_TH);
  localparam logic [AW:0] AemptyTh = PtrW'(AEMPTY_TH);

  logic [AW:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]   rd_ptr_q, rd_ptr_d;
  logic [AW:0]   level_q, level_d;
  logic [DW-1:0] mem_q [Depth];

  logic ptr_empty;
  logic ptr_full;
  logic rd_ok;
  logic wr_ok;

  // Extra wrap bit distinguishes full from empty when the index bits match.
  assign ptr_empty = (wr_ptr_q == rd_ptr_q);
  assign ptr_full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);

  // A pop in the same cycle frees a slot, so a write on full is still accepted.
  assign rd_ok = rd_en_i && !ptr_empty;
  assign wr_ok = wr_en_i && (!ptr_full || rd_ok);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (wr_ok) begin
        wr_ptr_d = wr_ptr_q + PtrW'(1);
      end
      if (rd_ok) begin
        rd_ptr_d = rd_ptr_q + PtrW'(1);
      end
      unique case ({wr_ok, rd_ok})
        2'b10:   level_d = level_q + PtrW'(1);
        2'b01:   level_d = level_q - PtrW'(1);
        default: level_d = level_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage is not reset; contents behind the pointers are don't-care.
  always_ff @(posedge clk) begin
    if (!reset && !flush_i && wr_ok) begin
      mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
    end
  end

  assign rd_data_o      = mem_q[rd_ptr_q[AW-1:0]];
  assign full_o         = ptr_full;
  assign empty_o        = ptr_empty;
  assign almost_full_o  = (level_q >= AfullTh);
  assign almost_empty_o = (level_q <= AemptyTh);
  assign level_o        = level_q;

`ifdef FIFO_ERR_FLAGS_EN
  logic overflow_q, overflow_d;
  logic underflow_q, underflow_d;
  logic set_ovf;
  logic set_unf;

  assign set_ovf = !flush_i && wr_en_i && !wr_ok;
  assign set_unf = !flush_i && rd_en_i && ptr_empty;

  // A new error in the same cycle as err_clr takes priority over the clear.
  always_comb begin
    overflow_d  = set_ovf || (overflow_q && !err_clr_i);
    underflow_d = set_unf || (underflow_q && !err_clr_i);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign overflow_o  = overflow_q;
  assign underflow_o = underflow_q;
`else
  logic unused_err_clr;
  assign unused_err_clr = err_clr_i;
  assign overflow_o     = 1'b0;
  assign underflow_o    = 1'b0;
`endif

endmodule
